ex_mem_buffer: RTL and testbench

EX/MEM pipeline boundary for the 64-bit RISC-V core. It captures the execute-stage result bundle: ALU result (including the 0/1 value produced by the set-less-than path), zero flag, store data, destination register, memory/writeback controls and PC. It then presents the bundle to the memory stage over a valid/ready handshake. A two-entry skid buffer (output register plus one skid register) sustains one transfer per cycle with a fully registered ready, and a synchronous flush kills all held entries.

---
 rtl/ex_mem_buffer.sv | 95 +++++++++
 tb/tb_ex_mem_buffer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_buffer.sv
// ex_mem_buffer: EX/MEM pipeline register built as a two-entry skid buffer.
// A bundle accepted at one edge is on out_* the next cycle; one transfer per cycle.
// in_ready comes only from rst_n and the skid flag, so out_ready has no combinational path to it.
//
// Ports:
//   clk, rst_n (synchronous, active-low), flush (synchronous kill of held entries)
//   in_valid/in_ready   : EX-side handshake, with payload in_alu_result, in_zero,
//                         in_store_data, in_rd, in_ctrl {reg_write, mem_read, mem_write, mem_to_reg}, in_pc
//   out_valid/out_ready : MEM-side handshake, with the registered payload out_*
module ex_mem_buffer #(
  parameter int XLEN = 64,
  parameter int REGW = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_alu_result,
  input  logic            in_zero,
  input  logic [XLEN-1:0] in_store_data,
  input  logic [REGW-1:0] in_rd,
  input  logic [3:0]      in_ctrl,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_alu_result,
  output logic            out_zero,
  output logic [XLEN-1:0] out_store_data,
  output logic [REGW-1:0] out_rd,
  output logic [3:0]      out_ctrl,
  output logic [XLEN-1:0] out_pc
);

  typedef struct packed {
    logic [XLEN-1:0] alu_result;
    logic            zero;
    logic [XLEN-1:0] store_data;
    logic [REGW-1:0] rd;
    logic [3:0]      ctrl;
    logic [XLEN-1:0] pc;
  } bundle_t;

  bundle_t in_bundle;
  bundle_t out_bundle;
  bundle_t skid_bundle;
  logic    skid_valid;
  logic    accept;
  logic    slot_free;

  assign in_bundle = {in_alu_result, in_zero, in_store_data, in_rd, in_ctrl, in_pc};

  // The skid register is the only thing that can block the input, so ready
  // never depends on what MEM is doing this cycle.
  assign in_ready  = rst_n & ~skid_valid;
  assign accept    = in_valid & in_ready;
  assign slot_free = ~out_valid | out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      skid_valid  <= 1'b0;
      out_bundle  <= '0;
      skid_bundle <= '0;
    end else if (flush) begin
      // Payload registers keep their contents; they are meaningless while invalid.
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (slot_free) begin
      if (skid_valid) begin
        // Older entry drains first; in_ready is low so no accept competes here.
        out_bundle <= skid_bundle;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else if (accept) begin
        out_bundle <= in_bundle;
        out_valid  <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (accept) begin
      // Output stalled: park the one extra bundle that ready let through.
      skid_bundle <= in_bundle;
      skid_valid  <= 1'b1;
    end
  end

  assign out_alu_result = out_bundle.alu_result;
  assign out_zero       = out_bundle.zero;
  assign out_store_data = out_bundle.store_data;
  assign out_rd         = out_bundle.rd;
  assign out_ctrl       = out_bundle.ctrl;
  assign out_pc         = out_bundle.pc;

endmodule

// File: tb/tb_ex_mem_buffer.sv
// tb_ex_mem_buffer: directed stimulus for ex_mem_buffer with a queue-based
// reference model checked every cycle, plus literal expectations per scenario.
module tb_ex_mem_buffer;
  localparam int XLEN = 64;
  localparam int REGW = 5;

  typedef struct packed {
    logic [XLEN-1:0] alu_result;
    logic            zero;
    logic [XLEN-1:0] store_data;
    logic [REGW-1:0] rd;
    logic [3:0]      ctrl;
    logic [XLEN-1:0] pc;
  } bun_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic            out_valid;
  logic            out_ready;
  bun_t            drv;
  logic [XLEN-1:0] in_alu_result, in_store_data, in_pc;
  logic            in_zero;
  logic [REGW-1:0] in_rd;
  logic [3:0]      in_ctrl;
  logic [XLEN-1:0] out_alu_result, out_store_data, out_pc;
  logic            out_zero;
  logic [REGW-1:0] out_rd;
  logic [3:0]      out_ctrl;
  bun_t            dut_bun;

  assign in_alu_result = drv.alu_result;
  assign in_zero       = drv.zero;
  assign in_store_data = drv.store_data;
  assign in_rd         = drv.rd;
  assign in_ctrl       = drv.ctrl;
  assign in_pc         = drv.pc;
  assign dut_bun = {out_alu_result, out_zero, out_store_data, out_rd, out_ctrl, out_pc};

  ex_mem_buffer #(.XLEN(XLEN), .REGW(REGW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_result(in_alu_result), .in_zero(in_zero), .in_store_data(in_store_data),
    .in_rd(in_rd), .in_ctrl(in_ctrl), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_alu_result(out_alu_result), .out_zero(out_zero), .out_store_data(out_store_data),
    .out_rd(out_rd), .out_ctrl(out_ctrl), .out_pc(out_pc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int dcount [32];
  bun_t q [$];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bun_t mk(input logic [63:0] alu, input int rd, input logic z,
                              input logic [3:0] c, input logic [63:0] pc);
    bun_t b;
    b.alu_result = alu;
    b.zero       = z;
    b.store_data = {alu[31:0], alu[63:32]} ^ 64'h5A5A_0F0F_A5A5_F0F0;
    b.rd         = REGW'(rd);
    b.ctrl       = c;
    b.pc         = pc;
    return b;
  endfunction

  // Reference model: a FIFO of at most two bundles.
  always @(posedge clk) begin : model
    bit xfer, acc;
    if (!rst_n) begin
      q.delete();
    end else begin
      xfer = (q.size() > 0) && out_ready;
      acc  = in_valid && (q.size() < 2);
      if (flush) q.delete();
      else begin
        if (xfer) void'(q.pop_front());
        if (acc) q.push_back(drv);
      end
    end
  end

  // Delivery monitor: count each bundle MEM actually takes, by rd.
  always @(posedge clk) begin
    if (rst_n && out_valid && out_ready) dcount[out_rd]++;
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("model_out_valid", out_valid, q.size() > 0);
    chk("model_in_ready", in_ready, rst_n && (q.size() < 2));
    if (q.size() > 0) chk("model_bundle", dut_bun, q[0]);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int rd);
    logic [31:0] r;
    r = rd;
    in_valid = 1'b1;
    drv = mk(64'h100 * rd + 3, rd, r[0], r[3:0], 64'h4000 + 4 * rd);
  endtask

  logic [63:0] sv [4];

  initial begin
    sv[0] = 64'h1;
    sv[1] = 64'h0;
    sv[2] = 64'hFFFF_FFFF_FFFF_FFFF;
    sv[3] = 64'h8000_0000_0000_0000;
    foreach (dcount[i]) dcount[i] = 0;

    // Reset held two cycles with input offered.
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0; in_valid = 1'b1;
    drv = mk(64'hDEAD, 31, 1'b1, 4'hF, 64'h44);
    step(); step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_alu", out_alu_result, 0);
    chk("rst_pc", out_pc, 0);
    chk("rst_ctrl", out_ctrl, 0);
    rst_n = 1'b1; in_valid = 1'b0;
    #1;
    chk("rel_in_ready", in_ready, 1);
    chk("rel_out_valid", out_valid, 0);

    // Streaming at full rate.
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      drv = mk(sv[i], i + 1, i[0], 4'(i + 8), 64'h2000 + 64'(i));
      step();
      chk("stream_valid", out_valid, 1);
      chk("stream_alu", out_alu_result, sv[i]);
      chk("stream_in_ready", in_ready, 1);
    end
    in_valid = 1'b0;
    step();
    chk("stream_drained", out_valid, 0);
    for (int i = 1; i <= 4; i++) chk("stream_delivered_once", dcount[i], 1);

    // Backpressure: stall from the third bundle.
    send(12); step(); chk("bp_rd_a", out_rd, 12);
    send(13); step(); chk("bp_rd_b", out_rd, 13);
    out_ready = 1'b0;
    send(14); step();
    chk("bp_skid_full_ready", in_ready, 0);
    chk("bp_hold_rd", out_rd, 13);
    send(15);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_stall_rd", out_rd, 13);
      chk("bp_stall_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    step();
    chk("bp_drain_rd_c", out_rd, 14);
    chk("bp_ready_back", in_ready, 1);
    step();
    chk("bp_rd_d", out_rd, 15);
    in_valid = 1'b0;
    step();
    chk("bp_empty", out_valid, 0);
    for (int i = 12; i <= 15; i++) chk("bp_delivered_once", dcount[i], 1);

    // Flush with both entries full and rd=7 offered.
    out_ready = 1'b0;
    send(5); step();
    send(6); step();
    chk("fl_full_ready", in_ready, 0);
    chk("fl_head_rd", out_rd, 5);
    send(7); flush = 1'b1; step();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_out_valid", out_valid, 0);
    chk("fl_in_ready", in_ready, 1);
    step();
    chk("fl_still_empty", out_valid, 0);

    // Flush on a cycle where the offered input would be accepted.
    send(8); step();
    chk("fa_head_rd", out_rd, 8);
    send(7); flush = 1'b1; step();
    flush = 1'b0; in_valid = 1'b0;
    chk("fa_out_valid", out_valid, 0);
    chk("fa_in_ready", in_ready, 1);
    step();
    chk("fa_dropped", out_valid, 0);
    chk("fl_rd7_never", dcount[7], 0);
    chk("fl_rd5_killed", dcount[5], 0);
    chk("fl_rd6_killed", dcount[6], 0);

    // Flush coinciding with an output transfer.
    send(9); step();
    out_ready = 1'b1; in_valid = 1'b0; flush = 1'b1; step();
    flush = 1'b0;
    chk("ft_rd9_delivered", dcount[9], 1);
    chk("ft_empty", out_valid, 0);

    // Reset mid-stall, with flush asserted in the same cycle.
    out_ready = 1'b0; in_valid = 1'b1;
    drv = mk(64'h77, 10, 1'b1, 4'b1010, 64'h1000); step();
    drv = mk(64'h78, 11, 1'b1, 4'b1010, 64'h1000); step();
    chk("rs_full_ready", in_ready, 0);
    chk("rs_zero", out_zero, 1);
    chk("rs_ctrl", out_ctrl, 4'b1010);
    chk("rs_pc", out_pc, 64'h1000);
    rst_n = 1'b0; flush = 1'b1; step();
    chk("rs_out_valid", out_valid, 0);
    chk("rs_in_ready_low", in_ready, 0);
    chk("rs_zero_clr", out_zero, 0);
    chk("rs_ctrl_clr", out_ctrl, 0);
    chk("rs_pc_clr", out_pc, 0);
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    chk("rs_in_ready_rel", in_ready, 1);
    step(); step();
    chk("rs_no_reissue_valid", out_valid, 0);
    chk("rs_rd10_lost", dcount[10], 0);
    chk("rs_rd11_lost", dcount[11], 0);
    chk("rs_pc_stays", out_pc, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
